// File: rtl/rv_operand_stage_if.sv
// Bundle of the operand stage's decode-side, register-file, bypass and issue-side signals.
// The stage uses the slave view; the upstream/downstream environment uses the master view.
interface rv_operand_stage_if #(
    parameter int XLEN      = 32,
    parameter int FWD_PORTS = 2
);
    logic                      i_valid;
    logic                      o_ready;
    logic                      i_flush;
    logic [4:0]                i_rs1;
    logic [4:0]                i_rs2;
    logic [4:0]                i_rd;
    logic [XLEN-1:0]           i_imm_i;
    logic [XLEN-1:0]           i_imm_j;
    logic [XLEN-1:0]           i_pc;
    logic                      i_op1_pc;
    logic [1:0]                i_op2_sel;
    logic                      i_jal;
    logic                      i_jalr;
    logic                      i_branch;
    logic                      i_store;
    logic                      i_reg_write;
    logic                      i_compressed;
    logic [XLEN-1:0]           i_reg1_data;
    logic [XLEN-1:0]           i_reg2_data;
    logic [FWD_PORTS-1:0]      i_fwd_valid;
    logic [5*FWD_PORTS-1:0]    i_fwd_rd;
    logic [XLEN*FWD_PORTS-1:0] i_fwd_data;
    logic                      o_valid;
    logic                      i_ready;
    logic [XLEN-1:0]           o_op1;
    logic [XLEN-1:0]           o_op2;
    logic [XLEN-1:0]           o_reg_data2;
    logic [XLEN-1:0]           o_pc;
    logic [XLEN-1:0]           o_pc_target;
    logic [XLEN-1:0]           o_pc_next;
    logic [4:0]                o_rd;
    logic                      o_reg_write;
    logic                      o_jump;
    logic                      o_branch;
    logic                      o_store;
    logic                      o_compressed;

    modport slave (
        input  i_valid, i_flush, i_rs1, i_rs2, i_rd, i_imm_i, i_imm_j, i_pc,
               i_op1_pc, i_op2_sel, i_jal, i_jalr, i_branch, i_store,
               i_reg_write, i_compressed, i_reg1_data, i_reg2_data,
               i_fwd_valid, i_fwd_rd, i_fwd_data, i_ready,
        output o_ready, o_valid, o_op1, o_op2, o_reg_data2, o_pc, o_pc_target,
               o_pc_next, o_rd, o_reg_write, o_jump, o_branch, o_store, o_compressed
    );

    modport master (
        output i_valid, i_flush, i_rs1, i_rs2, i_rd, i_imm_i, i_imm_j, i_pc,
               i_op1_pc, i_op2_sel, i_jal, i_jalr, i_branch, i_store,
               i_reg_write, i_compressed, i_reg1_data, i_reg2_data,
               i_fwd_valid, i_fwd_rd, i_fwd_data, i_ready,
        input  o_ready, o_valid, o_op1, o_op2, o_reg_data2, o_pc, o_pc_target,
               o_pc_next, o_rd, o_reg_write, o_jump, o_branch, o_store, o_compressed
    );
endinterface

// File: rtl/rv_operand_stage.sv
// RISC-V operand stage: resolves rs1/rs2 from register file or bypass, holds them across
// downstream stalls, and computes operands, jump/branch target and fall-through PC.
module rv_operand_stage #(
    parameter int XLEN      = 32,
    parameter int FWD_PORTS = 2,
    parameter int EXT_C     = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    rv_operand_stage_if.slave  bus
);
    typedef enum logic {SRC_LIVE = 1'b0, SRC_HELD = 1'b1} src_e;

    localparam logic [XLEN-1:0] PC_INC2 = XLEN'(2);
    localparam logic [XLEN-1:0] PC_INC4 = XLEN'(4);

    src_e            src_r, src_nxt_s;
    logic            valid_r;
    logic [4:0]      rs1_r, rs2_r, rd_r;
    logic [XLEN-1:0] imm_i_r, imm_j_r, pc_r;
    logic            op1_pc_r;
    logic [1:0]      op2_sel_r;
    logic            jal_r, jalr_r, branch_r, store_r, reg_write_r, compressed_r;
    logic [XLEN-1:0] hold1_r, hold2_r;

    logic            ready_s, capture_s, stall_s;
    logic [XLEN:0]   fwd1_s, fwd2_s;
    logic [XLEN-1:0] live1_s, live2_s, raw1_s, raw2_s, sum1_s;

    // Priority bypass lookup: {hit, data}; port 0 is youngest, so it is applied last.
    function automatic logic [XLEN:0] fwd_lookup(
        input logic [4:0]                rs,
        input logic [FWD_PORTS-1:0]      fv,
        input logic [5*FWD_PORTS-1:0]    frd,
        input logic [XLEN*FWD_PORTS-1:0] fdata
    );
        logic [XLEN:0] res;
        res = {(XLEN+1){1'b0}};
        for (int k = FWD_PORTS - 1; k >= 0; k--) begin
            if (fv[k] && (frd[5*k +: 5] == rs) && (rs != 5'd0)) begin
                res = {1'b1, fdata[XLEN*k +: XLEN]};
            end
        end
        return res;
    endfunction

    assign ready_s   = !valid_r || bus.i_ready;
    assign capture_s = bus.i_valid && ready_s && !bus.i_flush;
    assign stall_s   = valid_r && !bus.i_ready && !bus.i_flush;

    assign fwd1_s = fwd_lookup(rs1_r, bus.i_fwd_valid, bus.i_fwd_rd, bus.i_fwd_data);
    assign fwd2_s = fwd_lookup(rs2_r, bus.i_fwd_valid, bus.i_fwd_rd, bus.i_fwd_data);

    // Raw operand selection: x0 is hard zero, otherwise hold register or live bypass/regfile.
    always_comb begin
        live1_s = fwd1_s[XLEN] ? fwd1_s[XLEN-1:0] : bus.i_reg1_data;
        live2_s = fwd2_s[XLEN] ? fwd2_s[XLEN-1:0] : bus.i_reg2_data;
        if (rs1_r == 5'd0) begin
            raw1_s = {XLEN{1'b0}};
        end else if (src_r == SRC_HELD) begin
            raw1_s = hold1_r;
        end else begin
            raw1_s = live1_s;
        end
        if (rs2_r == 5'd0) begin
            raw2_s = {XLEN{1'b0}};
        end else if (src_r == SRC_HELD) begin
            raw2_s = hold2_r;
        end else begin
            raw2_s = live2_s;
        end
    end

    // Operand source next state: stall freezes operands, only a new capture goes live again.
    always_comb begin
        src_nxt_s = src_r;
        case (src_r)
            SRC_LIVE: begin
                if (capture_s) begin
                    src_nxt_s = SRC_LIVE;
                end else if (stall_s) begin
                    src_nxt_s = SRC_HELD;
                end else begin
                    src_nxt_s = SRC_LIVE;
                end
            end
            SRC_HELD: begin
                if (capture_s) begin
                    src_nxt_s = SRC_LIVE;
                end else begin
                    src_nxt_s = SRC_HELD;
                end
            end
            default: src_nxt_s = SRC_LIVE;
        endcase
    end

    // Operand source state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            src_r <= SRC_LIVE;
        end else begin
            src_r <= src_nxt_s;
        end
    end

    // Output valid: flush beats capture, capture beats drain.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_r <= 1'b0;
        end else if (bus.i_flush) begin
            valid_r <= 1'b0;
        end else if (capture_s) begin
            valid_r <= 1'b1;
        end else if (valid_r && bus.i_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Captured instruction fields.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rs1_r        <= 5'd0;
            rs2_r        <= 5'd0;
            rd_r         <= 5'd0;
            imm_i_r      <= {XLEN{1'b0}};
            imm_j_r      <= {XLEN{1'b0}};
            pc_r         <= {XLEN{1'b0}};
            op1_pc_r     <= 1'b0;
            op2_sel_r    <= 2'b00;
            jal_r        <= 1'b0;
            jalr_r       <= 1'b0;
            branch_r     <= 1'b0;
            store_r      <= 1'b0;
            reg_write_r  <= 1'b0;
            compressed_r <= 1'b0;
        end else if (capture_s) begin
            rs1_r        <= bus.i_rs1;
            rs2_r        <= bus.i_rs2;
            rd_r         <= bus.i_rd;
            imm_i_r      <= bus.i_imm_i;
            imm_j_r      <= bus.i_imm_j;
            pc_r         <= bus.i_pc;
            op1_pc_r     <= bus.i_op1_pc;
            op2_sel_r    <= bus.i_op2_sel;
            jal_r        <= bus.i_jal;
            jalr_r       <= bus.i_jalr;
            branch_r     <= bus.i_branch;
            store_r      <= bus.i_store;
            reg_write_r  <= bus.i_reg_write;
            compressed_r <= bus.i_compressed;
        end
    end

    // Hold registers: snapshot on entering a stall, then track late bypass writes.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hold1_r <= {XLEN{1'b0}};
            hold2_r <= {XLEN{1'b0}};
        end else if (src_r == SRC_LIVE) begin
            if (stall_s) begin
                hold1_r <= live1_s;
                hold2_r <= live2_s;
            end
        end else begin
            if (fwd1_s[XLEN]) begin
                hold1_r <= fwd1_s[XLEN-1:0];
            end
            if (fwd2_s[XLEN]) begin
                hold2_r <= fwd2_s[XLEN-1:0];
            end
        end
    end

    // Operand 2 mux.
    always_comb begin
        case (op2_sel_r)
            2'b01:   bus.o_op2 = imm_i_r;
            2'b10:   bus.o_op2 = imm_j_r;
            default: bus.o_op2 = raw2_s;
        endcase
    end

    assign sum1_s = raw1_s + imm_i_r;

    assign bus.o_ready      = ready_s;
    assign bus.o_valid      = valid_r;
    assign bus.o_op1        = op1_pc_r ? pc_r : raw1_s;
    assign bus.o_reg_data2  = raw2_s;
    assign bus.o_pc         = pc_r;
    assign bus.o_pc_target  = jalr_r ? {sum1_s[XLEN-1:1], 1'b0} : (pc_r + imm_j_r);
    assign bus.o_pc_next    = ((EXT_C != 0) && compressed_r) ? (pc_r + PC_INC2) : (pc_r + PC_INC4);
    assign bus.o_rd         = rd_r;
    assign bus.o_reg_write  = reg_write_r;
    assign bus.o_jump       = jal_r || jalr_r;
    assign bus.o_branch     = branch_r;
    assign bus.o_store      = store_r;
    assign bus.o_compressed = compressed_r;
endmodule

// File: tb/tb_rv_operand_stage.sv
// Directed bench for rv_operand_stage: two instances (EXT_C=1 and EXT_C=0) share stimulus.
module tb_rv_operand_stage;
    localparam int XLEN = 32;
    localparam int FP   = 2;

    logic i_clk;
    logic i_reset;
    int   n_checks = 0;
    int   n_err    = 0;

    rv_operand_stage_if #(.XLEN(XLEN), .FWD_PORTS(FP)) bus_a ();
    rv_operand_stage_if #(.XLEN(XLEN), .FWD_PORTS(FP)) bus_b ();

    rv_operand_stage #(.XLEN(XLEN), .FWD_PORTS(FP), .EXT_C(1)) dut_a (
        .i_clk(i_clk), .i_reset(i_reset), .bus(bus_a)
    );
    rv_operand_stage #(.XLEN(XLEN), .FWD_PORTS(FP), .EXT_C(0)) dut_b (
        .i_clk(i_clk), .i_reset(i_reset), .bus(bus_b)
    );

    assign bus_b.i_valid      = bus_a.i_valid;
    assign bus_b.i_flush      = bus_a.i_flush;
    assign bus_b.i_rs1        = bus_a.i_rs1;
    assign bus_b.i_rs2        = bus_a.i_rs2;
    assign bus_b.i_rd         = bus_a.i_rd;
    assign bus_b.i_imm_i      = bus_a.i_imm_i;
    assign bus_b.i_imm_j      = bus_a.i_imm_j;
    assign bus_b.i_pc         = bus_a.i_pc;
    assign bus_b.i_op1_pc     = bus_a.i_op1_pc;
    assign bus_b.i_op2_sel    = bus_a.i_op2_sel;
    assign bus_b.i_jal        = bus_a.i_jal;
    assign bus_b.i_jalr       = bus_a.i_jalr;
    assign bus_b.i_branch     = bus_a.i_branch;
    assign bus_b.i_store      = bus_a.i_store;
    assign bus_b.i_reg_write  = bus_a.i_reg_write;
    assign bus_b.i_compressed = bus_a.i_compressed;
    assign bus_b.i_reg1_data  = bus_a.i_reg1_data;
    assign bus_b.i_reg2_data  = bus_a.i_reg2_data;
    assign bus_b.i_fwd_valid  = bus_a.i_fwd_valid;
    assign bus_b.i_fwd_rd     = bus_a.i_fwd_rd;
    assign bus_b.i_fwd_data   = bus_a.i_fwd_data;
    assign bus_b.i_ready      = bus_a.i_ready;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_instr();
        bus_a.i_valid      = 1'b0;
        bus_a.i_flush      = 1'b0;
        bus_a.i_rs1        = 5'd0;
        bus_a.i_rs2        = 5'd0;
        bus_a.i_rd         = 5'd0;
        bus_a.i_imm_i      = 32'h0;
        bus_a.i_imm_j      = 32'h0;
        bus_a.i_pc         = 32'h0;
        bus_a.i_op1_pc     = 1'b0;
        bus_a.i_op2_sel    = 2'b00;
        bus_a.i_jal        = 1'b0;
        bus_a.i_jalr       = 1'b0;
        bus_a.i_branch     = 1'b0;
        bus_a.i_store      = 1'b0;
        bus_a.i_reg_write  = 1'b0;
        bus_a.i_compressed = 1'b0;
        bus_a.i_fwd_valid  = 2'b00;
        bus_a.i_fwd_rd     = 10'd0;
        bus_a.i_fwd_data   = 64'h0;
    endtask

    initial begin
        i_reset = 1'b1;
        clear_instr();
        bus_a.i_reg1_data = 32'h0;
        bus_a.i_reg2_data = 32'h0;
        bus_a.i_ready     = 1'b1;

        // Reset state
        step();
        chk("rst_valid", {31'd0, bus_a.o_valid}, 32'h0);
        chk("rst_ready", {31'd0, bus_a.o_ready}, 32'h1);
        chk("rst_pc_next", bus_a.o_pc_next, 32'h4);
        chk("rst_op1", bus_a.o_op1, 32'h0);
        chk("rst_target", bus_a.o_pc_target, 32'h0);
        i_reset = 1'b0;

        // JALR target with bit 0 cleared
        bus_a.i_valid = 1'b1; bus_a.i_pc = 32'h100; bus_a.i_jalr = 1'b1;
        bus_a.i_rs1 = 5'd5; bus_a.i_imm_i = 32'h4; bus_a.i_rd = 5'd1; bus_a.i_reg_write = 1'b1;
        step();
        bus_a.i_valid = 1'b0;
        bus_a.i_reg1_data = 32'h2003;
        #1;
        chk("jalr_valid", {31'd0, bus_a.o_valid}, 32'h1);
        chk("jalr_target", bus_a.o_pc_target, 32'h2006);
        chk("jalr_pc_next", bus_a.o_pc_next, 32'h104);
        chk("jalr_jump", {31'd0, bus_a.o_jump}, 32'h1);
        chk("jalr_op1", bus_a.o_op1, 32'h2003);
        chk("jalr_rd", {27'd0, bus_a.o_rd}, 32'h1);
        chk("jalr_regwr", {31'd0, bus_a.o_reg_write}, 32'h1);
        step();
        chk("drain_valid", {31'd0, bus_a.o_valid}, 32'h0);

        // Forwarding priority
        clear_instr();
        bus_a.i_valid = 1'b1; bus_a.i_rs1 = 5'd7; bus_a.i_jal = 1'b1; bus_a.i_pc = 32'h200;
        bus_a.i_imm_j = 32'h20; bus_a.i_op2_sel = 2'b01; bus_a.i_imm_i = 32'h11;
        step();
        bus_a.i_valid = 1'b0;
        bus_a.i_reg1_data = 32'h1234;
        bus_a.i_fwd_valid = 2'b11;
        bus_a.i_fwd_rd    = {5'd7, 5'd7};
        bus_a.i_fwd_data  = {32'hAA, 32'h55};
        #1;
        chk("fwd_both", bus_a.o_op1, 32'h55);
        chk("fwd_op2_immi", bus_a.o_op2, 32'h11);
        chk("jal_target", bus_a.o_pc_target, 32'h220);
        chk("jal_jump", {31'd0, bus_a.o_jump}, 32'h1);
        bus_a.i_fwd_valid = 2'b10;
        #1;
        chk("fwd_port1", bus_a.o_op1, 32'hAA);
        bus_a.i_fwd_valid = 2'b00;
        #1;
        chk("fwd_none", bus_a.o_op1, 32'h1234);

        // Back-to-back capture with rs1 = x0
        clear_instr();
        bus_a.i_valid = 1'b1; bus_a.i_rs2 = 5'd3; bus_a.i_op2_sel = 2'b10; bus_a.i_imm_j = 32'h40;
        step();
        bus_a.i_valid = 1'b0;
        bus_a.i_reg1_data = 32'h999; bus_a.i_reg2_data = 32'h333;
        bus_a.i_fwd_valid = 2'b11; bus_a.i_fwd_rd = {5'd0, 5'd0}; bus_a.i_fwd_data = {32'hAA, 32'h55};
        #1;
        chk("b2b_valid", {31'd0, bus_a.o_valid}, 32'h1);
        chk("x0_op1", bus_a.o_op1, 32'h0);
        chk("op2_immj", bus_a.o_op2, 32'h40);
        chk("reg_data2", bus_a.o_reg_data2, 32'h333);
        bus_a.i_fwd_valid = 2'b00;
        step();

        // Stall: operands held, late forward updates rs2 only
        clear_instr();
        bus_a.i_ready = 1'b0;
        bus_a.i_valid = 1'b1; bus_a.i_rs1 = 5'd1; bus_a.i_rs2 = 5'd2; bus_a.i_store = 1'b1;
        step();
        bus_a.i_valid = 1'b0;
        bus_a.i_reg1_data = 32'h11; bus_a.i_reg2_data = 32'h22;
        #1;
        chk("stall_ready", {31'd0, bus_a.o_ready}, 32'h0);
        chk("stall_c1_op1", bus_a.o_op1, 32'h11);
        chk("stall_c1_op2", bus_a.o_op2, 32'h22);
        step();
        bus_a.i_reg1_data = 32'h12;
        bus_a.i_fwd_valid = 2'b01; bus_a.i_fwd_rd = {5'd0, 5'd2}; bus_a.i_fwd_data = {32'h0, 32'h77};
        #1;
        chk("stall_c2_op1", bus_a.o_op1, 32'h11);
        chk("stall_c2_op2", bus_a.o_op2, 32'h22);
        step();
        bus_a.i_fwd_valid = 2'b00;
        bus_a.i_reg1_data = 32'h13;
        #1;
        chk("stall_c3_op1", bus_a.o_op1, 32'h11);
        chk("stall_c3_op2", bus_a.o_op2, 32'h77);
        chk("stall_c3_valid", {31'd0, bus_a.o_valid}, 32'h1);
        chk("stall_store", {31'd0, bus_a.o_store}, 32'h1);
        bus_a.i_ready = 1'b1;
        #1;
        chk("release_ready", {31'd0, bus_a.o_ready}, 32'h1);
        step();
        chk("release_once", {31'd0, bus_a.o_valid}, 32'h0);

        // Flush with incoming instruction while stalled
        clear_instr();
        bus_a.i_ready = 1'b0;
        bus_a.i_valid = 1'b1; bus_a.i_pc = 32'h300;
        step();
        bus_a.i_valid = 1'b0;
        step();
        chk("pre_flush_valid", {31'd0, bus_a.o_valid}, 32'h1);
        chk("pre_flush_pc", bus_a.o_pc, 32'h300);
        bus_a.i_flush = 1'b1; bus_a.i_valid = 1'b1; bus_a.i_pc = 32'h400;
        step();
        bus_a.i_flush = 1'b0; bus_a.i_valid = 1'b0;
        #1;
        chk("flush_valid", {31'd0, bus_a.o_valid}, 32'h0);
        chk("flush_ready", {31'd0, bus_a.o_ready}, 32'h1);
        step();
        chk("flush_dropped", {31'd0, bus_a.o_valid}, 32'h0);

        // PC wrap with compressed instruction, both EXT_C settings
        clear_instr();
        bus_a.i_ready = 1'b1;
        bus_a.i_valid = 1'b1; bus_a.i_pc = 32'hFFFF_FFFE; bus_a.i_compressed = 1'b1;
        step();
        bus_a.i_valid = 1'b0;
        #1;
        chk("wrap_extc1", bus_a.o_pc_next, 32'h0);
        chk("wrap_extc0", bus_b.o_pc_next, 32'h2);
        chk("wrap_compressed", {31'd0, bus_a.o_compressed}, 32'h1);
        step();

        // Asynchronous reset mid-stall
        clear_instr();
        bus_a.i_ready = 1'b0;
        bus_a.i_valid = 1'b1; bus_a.i_rs1 = 5'd4; bus_a.i_pc = 32'h500;
        step();
        bus_a.i_valid = 1'b0;
        step();
        chk("pre_rst_valid", {31'd0, bus_a.o_valid}, 32'h1);
        #2;
        i_reset = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, bus_a.o_valid}, 32'h0);
        chk("async_rst_ready", {31'd0, bus_a.o_ready}, 32'h1);
        chk("async_rst_pc_next", bus_a.o_pc_next, 32'h4);
        chk("async_rst_valid_b", {31'd0, bus_b.o_valid}, 32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;
        bus_a.i_ready = 1'b1;
        step();
        chk("post_rst_no_hs", {31'd0, bus_a.o_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/rv_operand_stage.md
RV_OPERAND_STAGE -- requirements
Module: rv_operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width (32 or 64).
REQ-002 SHALL have parameter FWD_PORTS, default 2: number of forwarding sources; index 0 is youngest and has highest priority.
REQ-003 SHALL have parameter EXT_C, default 1: when 1, the compressed flag selects a PC increment of 2; when 0, the increment is always 4.
REQ-004 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_valid / o_ready  in / out  1 / 1  upstream decode handshake.
REQ-007 i_flush  in  1  kill the held and incoming instruction.
REQ-008 i_rs1, i_rs2, i_rd  in  5 each  register indices.
REQ-009 i_imm_i, i_imm_j, i_pc  in  XLEN each  immediates and instruction PC.
REQ-010 i_op1_pc  in  1  op1 = pc; i_op2_sel  in  2  00 reg2, 01 imm_i, 10 imm_j, 11 reg2.
REQ-011 i_jal, i_jalr, i_branch, i_store, i_reg_write, i_compressed  in  1 each  instruction class flags.
REQ-012 i_reg1_data, i_reg2_data  in  XLEN each  synchronous register-file read data, valid the cycle after capture.
REQ-013 i_fwd_valid  in  FWD_PORTS; i_fwd_rd  in  5*FWD_PORTS; i_fwd_data  in  XLEN*FWD_PORTS  bypass sources.
REQ-014 o_valid / i_ready  out / in  1 / 1  downstream handshake.
REQ-015 o_op1, o_op2, o_reg_data2, o_pc, o_pc_target, o_pc_next  out  XLEN each  resolved operands, store data, and PCs.
REQ-016 o_rd  out  5; o_reg_write, o_jump, o_branch, o_store, o_compressed  out  1 each  registered control.

Function
REQ-017 SHALL drive o_ready = !o_valid | i_ready, combinationally.
REQ-018 SHALL capture all i_* control and immediate fields, and set o_valid, on an edge with i_valid & o_ready & !i_flush.
REQ-019 SHALL clear o_valid on an edge with o_valid & i_ready and no new capture.
REQ-020 SHALL clear o_valid on any edge with i_flush=1, regardless of i_valid, i_ready or stall state; flush wins over capture.
REQ-021 SHALL keep internal state SRC in {LIVE, HELD}; a capture sets LIVE.
REQ-022 In LIVE, each raw operand SHALL be the matching forwarding data, else i_regN_data.
REQ-023 SHALL transition LIVE->HELD on an edge with o_valid & !i_ready & !i_flush, latching the resolved rs1/rs2 values into hold registers.
REQ-024 In HELD, each raw operand SHALL come from its hold register; a hold register SHALL update on any edge where a forwarding port matches its rs.
REQ-025 SHALL return HELD->LIVE only on a new capture; a drain without capture leaves the stage empty.
REQ-026 Forwarding match for port k SHALL require i_fwd_valid[k], i_fwd_rd[k]==rsN, and rsN!=0; the lowest matching k wins.
REQ-027 When rsN==0, the raw operand SHALL be 0 regardless of the register file or forwarding.
REQ-028 o_op1 SHALL be pc when op1_pc=1, else the raw rs1 value.
REQ-029 o_op2 SHALL select per op2_sel; o_reg_data2 SHALL always be the raw rs2 value.
REQ-030 o_pc_target SHALL be (raw rs1 + imm_i) with bit 0 cleared when jalr, else pc + imm_j.
REQ-031 All PC arithmetic SHALL be modulo 2^XLEN; wrap-around SHALL be silent.
REQ-032 o_pc_next SHALL be pc + 2 when EXT_C & compressed, else pc + 4.
REQ-033 o_jump SHALL equal jal | jalr; the remaining control outputs SHALL be the registered copies.
REQ-034 All outputs SHALL be stable while o_valid & !i_ready, except operand updates caused by forwarding.

Reset
REQ-035 On i_reset, the block SHALL immediately set o_valid=0, SRC=LIVE, and all captured fields and hold registers to 0.
REQ-036 While o_valid=0, o_ready SHALL be 1, and the datapath outputs SHALL reflect the cleared registers (o_pc_next=4).
REQ-037 Reset asserted mid-stall SHALL discard the held instruction; no output handshake SHALL occur in the cycle after release.

Verification
REQ-038 Capture pc=0x100, jalr, rs1=5, reg1 data 0x2003, imm_i=4 -> next cycle o_pc_target=0x2006, o_pc_next=0x104, o_jump=1.
REQ-039 rs1=7, fwd port1 rd=7 data 0xAA, port0 rd=7 data 0x55 -> o_op1=0x55; with rs1=0 instead -> o_op1=0.
REQ-040 Stall with i_ready=0 for 3 cycles, change i_reg1_data each cycle, fwd rd=rs2 data 0x77 in cycle 2 -> o_op1 stays at the cycle-1 value, o_op2 becomes 0x77; one handshake on release.
REQ-041 i_flush together with i_valid while stalled -> o_valid=0 next cycle and the incoming instruction is dropped.
REQ-042 XLEN=32, pc=0xFFFFFFFE, compressed=1, EXT_C=1 -> o_pc_next=0x00000000; with EXT_C=0 -> 0x00000002.
REQ-043 Assert i_reset asynchronously mid-stall -> o_valid=0 and o_ready=1 before the next edge.
